// File: rtl/uart_apb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_apb_pkg : register offsets, LSR layout and APB state encoding    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package uart_apb_pkg;

    localparam logic [5:0] UART_RBR_THR = 6'h00;
    localparam logic [5:0] UART_IER     = 6'h04;
    localparam logic [5:0] UART_LSR     = 6'h14;

    // Bit order matches the driver's view of LSR, MSB first.
    typedef struct packed {
        logic       rsvd7;
        logic       xmitr_empty;
        logic       thr_empty;
        logic [2:0] rsvd;
        logic       overrun;
        logic       data_rdy;
    } uart_status_t;

    typedef enum logic [0:0] {
        APB_IDLE   = 1'b0,
        APB_ACCESS = 1'b1
    } apb_state_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo_byte.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_fifo_byte : first-word-fall-through byte FIFO                    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module sync_fifo_byte #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     resn,
    input  logic                     i_push,
    input  logic [7:0]               i_push_data,
    input  logic                     i_pop,
    output logic [7:0]               o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int                  c_AW   = $clog2(DEPTH);
    localparam logic [c_AW:0]       c_FULL = DEPTH[c_AW:0];

    logic [7:0]      r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic            w_pop_ok;
    logic            w_push_ok;

    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign w_pop_ok  = i_pop && (r_count != '0);
    assign w_push_ok = i_push && ((r_count != c_FULL) || w_pop_ok);

    assign o_full  = (r_count == c_FULL);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = o_empty ? 8'h00 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!resn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_apb_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_apb_responder : APB model of the UART register file bridged to   |
// | RX/TX byte streams.                                      Rev 1.0      |
// +----------------------------------------------------------------------+
module uart_apb_responder
    import uart_apb_pkg::*;
#(
    parameter int FIFO_DEPTH  = 16,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        resn,
    input  logic        apb_psel_i,
    input  logic        apb_penable_i,
    input  logic        apb_pwrite_i,
    input  logic [5:0]  apb_paddr_i,
    input  logic [31:0] apb_pwdata_i,
    output logic        apb_pready_o,
    output logic        apb_pslverr_o,
    output logic [31:0] apb_prdata_o,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        interrupt_uart
);
    localparam int         c_CW   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [3:0] c_WAIT = WAIT_STATES[3:0];

    apb_state_t   r_state;
    logic [3:0]   r_wait_cnt;
    logic [1:0]   r_ier;
    logic         r_overrun;
    logic         r_irq;

    logic         w_pready;
    logic         w_rd;
    logic         w_wr;
    logic         w_rx_pop;
    logic         w_tx_push;
    logic         w_tx_pop;
    logic         w_lsr_rd;
    logic         w_ier_wr;
    logic         w_ovr_set;
    logic [7:0]   w_rx_head;
    logic         w_rx_full;
    logic         w_rx_empty;
    logic [c_CW-1:0] w_rx_count;
    logic         w_tx_full;
    logic         w_tx_empty;
    logic [c_CW-1:0] w_tx_count;
    logic [31:0]  w_prdata;
    logic         w_pslverr;
    uart_status_t w_lsr;
    logic         w_unused;

    assign w_pready  = (r_state == APB_ACCESS) && (r_wait_cnt == 4'd0) && apb_psel_i && apb_penable_i;
    assign w_rd      = w_pready && !apb_pwrite_i;
    assign w_wr      = w_pready && apb_pwrite_i;
    assign w_rx_pop  = w_rd && (apb_paddr_i == UART_RBR_THR) && !w_rx_empty;
    assign w_tx_push = w_wr && (apb_paddr_i == UART_RBR_THR) && !w_tx_full;
    assign w_tx_pop  = !w_tx_empty && m_axis_tready;
    assign w_lsr_rd  = w_rd && (apb_paddr_i == UART_LSR);
    assign w_ier_wr  = w_wr && (apb_paddr_i == UART_IER);
    assign w_ovr_set = s_axis_tvalid && w_rx_full && !w_rx_pop;

    always_comb begin
        w_lsr             = '0;
        w_lsr.data_rdy    = !w_rx_empty;
        w_lsr.overrun     = r_overrun;
        w_lsr.thr_empty   = w_tx_empty;
        w_lsr.xmitr_empty = w_tx_empty;
    end

    // Read data and error are driven only in the completion cycle.
    always_comb begin
        w_prdata  = '0;
        w_pslverr = 1'b0;
        if (w_pready) begin
            case (apb_paddr_i)
                UART_RBR_THR: begin
                    if (!apb_pwrite_i) w_prdata  = {24'h0, w_rx_head};
                    else               w_pslverr = w_tx_full;
                end
                UART_IER: if (!apb_pwrite_i) w_prdata = {30'h0, r_ier};
                UART_LSR: if (!apb_pwrite_i) w_prdata = {24'h0, w_lsr};
                default:  w_pslverr = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resn) begin
            r_state    <= APB_IDLE;
            r_wait_cnt <= 4'd0;
            r_ier      <= 2'b00;
            r_overrun  <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            case (r_state)
                APB_IDLE: begin
                    if (apb_psel_i && !apb_penable_i) begin
                        r_state    <= APB_ACCESS;
                        r_wait_cnt <= c_WAIT;
                    end
                end
                APB_ACCESS: begin
                    if (!apb_psel_i || w_pready) begin
                        r_state <= APB_IDLE;
                    end else if (r_wait_cnt != 4'd0) begin
                        r_wait_cnt <= r_wait_cnt - 4'd1;
                    end
                end
                default: r_state <= APB_IDLE;
            endcase
            if (w_ier_wr) begin
                r_ier <= apb_pwdata_i[1:0];
            end
            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end else if (w_lsr_rd) begin
                r_overrun <= 1'b0;
            end
            r_irq <= (r_ier[0] && !w_rx_empty) || (r_ier[1] && w_tx_empty);
        end
    end

    sync_fifo_byte #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk         (clk),
        .resn        (resn),
        .i_push      (s_axis_tvalid),
        .i_push_data (s_axis_tdata),
        .i_pop       (w_rx_pop),
        .o_head      (w_rx_head),
        .o_full      (w_rx_full),
        .o_empty     (w_rx_empty),
        .o_count     (w_rx_count)
    );

    sync_fifo_byte #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk         (clk),
        .resn        (resn),
        .i_push      (w_tx_push),
        .i_push_data (apb_pwdata_i[7:0]),
        .i_pop       (w_tx_pop),
        .o_head      (m_axis_tdata),
        .o_full      (w_tx_full),
        .o_empty     (w_tx_empty),
        .o_count     (w_tx_count)
    );

    assign apb_pready_o   = w_pready;
    assign apb_pslverr_o  = w_pslverr;
    assign apb_prdata_o   = w_prdata;
    assign s_axis_tready  = 1'b1;
    assign m_axis_tvalid  = !w_tx_empty;
    assign interrupt_uart = r_irq;
    assign w_unused       = ^{apb_pwdata_i[31:8], w_rx_count, w_tx_count};

endmodule
`default_nettype wire

// File: tb/tb_uart_apb_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_uart_apb_responder : directed + randomized bench with a queue model|
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_uart_apb_responder;
    localparam int DEPTH = 16;
    localparam int WAIT  = 2;

    logic        clk = 1'b0;
    logic        resn;
    logic        psel, penable, pwrite, psel_z, penable_z;
    logic [5:0]  paddr;
    logic [31:0] pwdata;
    logic        pready, pslverr;
    logic [31:0] prdata;
    logic [7:0]  s_data, m_data;
    logic        s_valid, s_ready, m_valid, m_ready, irq;
    logic        z_pready, z_pslverr, z_sready, z_mvalid, z_irq;
    logic [31:0] z_prdata;
    logic [7:0]  z_mdata;
    logic        zero_bit;
    logic [7:0]  zero_byte;

    always #5 clk = ~clk;

    uart_apb_responder #(.FIFO_DEPTH(DEPTH), .WAIT_STATES(WAIT)) dut (
        .clk(clk), .resn(resn),
        .apb_psel_i(psel), .apb_penable_i(penable), .apb_pwrite_i(pwrite),
        .apb_paddr_i(paddr), .apb_pwdata_i(pwdata),
        .apb_pready_o(pready), .apb_pslverr_o(pslverr), .apb_prdata_o(prdata),
        .s_axis_tdata(s_data), .s_axis_tvalid(s_valid), .s_axis_tready(s_ready),
        .m_axis_tdata(m_data), .m_axis_tvalid(m_valid), .m_axis_tready(m_ready),
        .interrupt_uart(irq)
    );

    uart_apb_responder #(.FIFO_DEPTH(DEPTH), .WAIT_STATES(0)) dut_z (
        .clk(clk), .resn(resn),
        .apb_psel_i(psel_z), .apb_penable_i(penable_z), .apb_pwrite_i(pwrite),
        .apb_paddr_i(paddr), .apb_pwdata_i(pwdata),
        .apb_pready_o(z_pready), .apb_pslverr_o(z_pslverr), .apb_prdata_o(z_prdata),
        .s_axis_tdata(zero_byte), .s_axis_tvalid(zero_bit), .s_axis_tready(z_sready),
        .m_axis_tdata(z_mdata), .m_axis_tvalid(z_mvalid), .m_axis_tready(zero_bit),
        .interrupt_uart(z_irq)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, act, req);
        end
    endtask

    // Behavioural model: byte queues plus a few flags, advanced once per clock.
    logic [7:0] rxq[$];
    logic [7:0] txq[$];
    logic [1:0] m_ier;
    logic       m_ovr, m_irq;
    logic       exp_done, chk_en, rand_line, slow_tx;
    logic       mdl_rxpop, mdl_txpush, mdl_lsrrd, mdl_ovrset;

    always @(posedge clk) begin
        if (!resn) begin
            rxq.delete(); txq.delete();
            m_ier = 2'b00; m_ovr = 1'b0; m_irq = 1'b0;
        end else begin
            m_irq      = (m_ier[0] && rxq.size() != 0) || (m_ier[1] && txq.size() == 0);
            mdl_rxpop  = exp_done && !pwrite && paddr == 6'h00 && rxq.size() != 0;
            mdl_txpush = exp_done && pwrite && paddr == 6'h00 && txq.size() < DEPTH;
            mdl_lsrrd  = exp_done && !pwrite && paddr == 6'h14;
            mdl_ovrset = 1'b0;
            if (mdl_rxpop) void'(rxq.pop_front());
            if (s_valid) begin
                if (rxq.size() < DEPTH) rxq.push_back(s_data);
                else                    mdl_ovrset = 1'b1;
            end
            if (mdl_ovrset)     m_ovr = 1'b1;
            else if (mdl_lsrrd) m_ovr = 1'b0;
            if (m_ready && txq.size() != 0) void'(txq.pop_front());
            if (mdl_txpush) txq.push_back(pwdata[7:0]);
            if (exp_done && pwrite && paddr == 6'h04) m_ier = pwdata[1:0];
        end
    end

    function automatic logic [31:0] exp_rdata();
        logic te;
        te = (txq.size() == 0);
        case (paddr)
            6'h00:   return (rxq.size() != 0) ? {24'h0, rxq[0]} : 32'h0;
            6'h04:   return {30'h0, m_ier};
            6'h14:   return {24'h0, 1'b0, te, te, 3'b000, m_ovr, rxq.size() != 0};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic exp_err();
        if (paddr == 6'h00) return pwrite && (txq.size() == DEPTH);
        return !(paddr == 6'h04 || paddr == 6'h14);
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("pready", pready, exp_done);
            if (exp_done) begin
                check("pslverr", pslverr, exp_err());
                if (!pwrite) check("prdata", prdata, exp_rdata());
            end else begin
                check("prdata_idle", prdata, 32'h0);
                check("pslverr_idle", pslverr, 1'b0);
            end
            check("m_tvalid", m_valid, txq.size() != 0);
            if (txq.size() != 0) check("m_tdata", m_data, txq[0]);
            check("irq", irq, m_irq);
            check("s_tready", s_ready, 1'b1);
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_line) begin
            s_valid = ($urandom_range(0, 2) == 0);
            s_data  = 8'($urandom);
            m_ready = slow_tx ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 1);
        end
    end

    task automatic apb(input logic wr, input logic [5:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic err);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        @(posedge clk); #1;
        penable = 1'b1;
        for (int i = 0; i < WAIT; i++) begin
            @(posedge clk); #1;
        end
        exp_done = 1'b1;
        @(negedge clk);
        rd = prdata; err = pslverr;
        @(posedge clk); #1;
        exp_done = 1'b0; psel = 1'b0; penable = 1'b0;
    endtask

    task automatic push_rx(input logic [7:0] b);
        @(posedge clk); #1;
        s_valid = 1'b1; s_data = b;
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    logic [31:0] rdv;
    logic        e;
    logic [5:0]  ra;

    initial begin
        resn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        psel_z = 1'b0; penable_z = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        zero_bit = 1'b0; zero_byte = 8'h00;
        exp_done = 1'b0; chk_en = 1'b0; rand_line = 1'b0; slow_tx = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk_en = 1'b1;
        @(posedge clk); #1 resn = 1'b1;

        // Zero-wait instance: pready in the first access cycle.
        @(posedge clk); #1 psel_z = 1'b1; paddr = 6'h14; pwrite = 1'b0;
        @(negedge clk); check("z_setup_pready", z_pready, 1'b0);
        @(posedge clk); #1 penable_z = 1'b1;
        @(negedge clk);
        check("z_pready", z_pready, 1'b1);
        check("z_lsr", z_prdata, 32'h60);
        check("z_pslverr", z_pslverr, 1'b0);
        check("z_irq", z_irq, 1'b0);
        @(posedge clk); #1 psel_z = 1'b0; penable_z = 1'b0;
        @(negedge clk); check("z_pready_after", z_pready, 1'b0);

        apb(1'b0, 6'h14, 0, rdv, e); check("lsr_reset", rdv, 32'h60);

        apb(1'b1, 6'h00, 32'h41, rdv, e);
        @(negedge clk); check("thr_tvalid", m_valid, 1'b1); check("thr_tdata", m_data, 8'h41);
        apb(1'b0, 6'h14, 0, rdv, e); check("lsr_tx_busy", rdv, 32'h00);
        @(posedge clk); #1 m_ready = 1'b1;
        @(posedge clk); #1 m_ready = 1'b0;
        apb(1'b0, 6'h14, 0, rdv, e); check("lsr_tx_done", rdv, 32'h60);

        push_rx(8'hA5);
        apb(1'b0, 6'h14, 0, rdv, e); check("lsr_rx", rdv, 32'h61);
        apb(1'b0, 6'h00, 0, rdv, e); check("rbr_a5", rdv, 32'hA5);
        apb(1'b0, 6'h14, 0, rdv, e); check("lsr_rx_empty", rdv, 32'h60);
        apb(1'b0, 6'h00, 0, rdv, e); check("rbr_empty", rdv, 32'h0);

        @(posedge clk); #1;
        for (int i = 0; i <= 16; i++) begin
            s_valid = 1'b1; s_data = 8'(i);
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        apb(1'b0, 6'h14, 0, rdv, e); check("lsr_overrun", rdv, 32'h63);
        apb(1'b0, 6'h14, 0, rdv, e); check("lsr_ovr_clr", rdv, 32'h61);
        for (int i = 0; i < 16; i++) begin
            apb(1'b0, 6'h00, 0, rdv, e); check("rbr_seq", rdv, 32'(i));
        end
        apb(1'b0, 6'h00, 0, rdv, e); check("rbr_lost", rdv, 32'h0);

        // Full RX with the line still pushing: set wins over LSR clear; pop frees a slot.
        for (int i = 0; i < 16; i++) push_rx(8'(8'h80 + i));
        @(posedge clk); #1 s_valid = 1'b1; s_data = 8'hEE;
        apb(1'b0, 6'h14, 0, rdv, e); check("lsr_set_race", rdv, 32'h63);
        apb(1'b0, 6'h00, 0, rdv, e); check("rbr_full_pop", rdv, 32'h80);
        @(posedge clk); #1 s_valid = 1'b0;
        apb(1'b0, 6'h14, 0, rdv, e); check("lsr_ovr_kept", rdv, 32'h63);
        for (int i = 0; i < 16; i++) apb(1'b0, 6'h00, 0, rdv, e);
        check("rbr_last_ee", rdv, 32'hEE);

        apb(1'b0, 6'h3C, 0, rdv, e); check("bad_addr_err", e, 1'b1); check("bad_addr_rd", rdv, 32'h0);
        for (int i = 0; i <= 16; i++) begin
            apb(1'b1, 6'h00, 32'(8'h30 + i), rdv, e); check("thr_full_err", e, i == 16);
        end
        @(posedge clk); #1 m_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1 m_ready = 1'b0;

        // psel drop mid-access leaves no trace.
        @(posedge clk); #1 psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 6'h00; pwdata = 32'h55;
        @(posedge clk); #1 penable = 1'b1;
        @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
        apb(1'b0, 6'h14, 0, rdv, e); check("lsr_after_abort", rdv, 32'h60);

        apb(1'b1, 6'h04, 32'hFFFF_FF01, rdv, e);
        apb(1'b0, 6'h04, 0, rdv, e); check("ier_rd", rdv, 32'h1);
        push_rx(8'h5A);
        @(posedge clk); #1; @(negedge clk); check("irq_rx", irq, 1'b1);
        apb(1'b0, 6'h00, 0, rdv, e);
        @(posedge clk); #1; @(negedge clk); check("irq_rx_clr", irq, 1'b0);
        apb(1'b1, 6'h04, 32'h2, rdv, e);
        @(posedge clk); #1; @(negedge clk); check("irq_thr", irq, 1'b1);

        // Reset in the middle of a transfer with data in both FIFOs.
        push_rx(8'h11);
        apb(1'b1, 6'h00, 32'h22, rdv, e);
        @(posedge clk); #1 psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 6'h00; pwdata = 32'h77;
        @(posedge clk); #1 penable = 1'b1; resn = 1'b0;
        @(posedge clk); #1 resn = 1'b1; psel = 1'b0; penable = 1'b0;
        @(negedge clk); check("rst_irq", irq, 1'b0); check("rst_tvalid", m_valid, 1'b0);
        apb(1'b0, 6'h14, 0, rdv, e); check("lsr_after_rst", rdv, 32'h60);
        apb(1'b0, 6'h04, 0, rdv, e); check("ier_after_rst", rdv, 32'h0);

        rand_line = 1'b1;
        for (int k = 0; k < 300; k++) begin
            if (k == 150) slow_tx = 1'b0;
            case ($urandom_range(0, 5))
                0, 1:    ra = 6'h00;
                2:       ra = 6'h04;
                3, 4:    ra = 6'h14;
                default: ra = 6'($urandom);
            endcase
            apb(1'($urandom_range(0, 1)), ra, $urandom, rdv, e);
        end
        rand_line = 1'b0;
        @(posedge clk); #1 s_valid = 1'b0; m_ready = 1'b0;
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
